// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA overlay-box controller.
// Holds the 800x600@60 timing constants, the box origin limits and widths,
// and the per-button step FSM state type.
package vga_pkg;

    // Horizontal timing, in hs_count pixels.
    localparam int unsigned H_SYNC   = 128;
    localparam int unsigned H_BACK   = 88;
    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FRONT  = 40;
    localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

    // Vertical timing, in vs_count lines.
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BACK   = 23;
    localparam int unsigned V_ACTIVE = 600;
    localparam int unsigned V_FRONT  = 1;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    // Box origin limits: the minimum is the first visible pixel/line.
    localparam int unsigned H_MIN = H_SYNC + H_BACK;  // 216
    localparam int unsigned H_MAX = H_MIN + 600;      // 816
    localparam int unsigned V_MIN = V_SYNC + V_BACK;  // 27
    localparam int unsigned V_MAX = V_MIN + 400;      // 427

    // Origin register widths.
    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    typedef enum logic [1:0] {
        RELEASED,
        HELD_WAIT,
        HELD_REP
    } step_state_e;

endpackage

// File: rtl/btn_debounce_rep.sv
// Pushbutton conditioner: 2-flop synchroniser, stability-counter debouncer
// and auto-repeat step generator for one active-low button.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   btn   - raw active-low button, asynchronous to clk
//   step  - one-cycle pulse on accepted press and on each auto-repeat
module btn_debounce_rep
    import vga_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 400000,
    parameter int unsigned REP_DELAY  = 20000000,
    parameter int unsigned REP_PERIOD = 4000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic step
);

    localparam int unsigned CNT_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned TMR_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REP_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REP_PERIOD - 1);

    logic              sync1;
    logic              sync2;
    logic              level;
    logic [CNT_W-1:0]  db_cnt;
    step_state_e       state;
    logic [TMR_W-1:0]  timer;

    // Reset to the released (high) level so nothing fires out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // The debounced level follows the synced level only after it has
    // disagreed for DB_CYCLES consecutive clocks; any agreement restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= 1'b1;
            db_cnt <= '0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            timer <= '0;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                RELEASED: begin
                    if (!level) begin
                        step  <= 1'b1;
                        timer <= '0;
                        state <= HELD_WAIT;
                    end
                end
                HELD_WAIT: begin
                    if (level) begin
                        state <= RELEASED;
                    end else if (timer == DELAY_LAST) begin
                        step  <= 1'b1;
                        timer <= '0;
                        state <= HELD_REP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HELD_REP: begin
                    if (level) begin
                        state <= RELEASED;
                    end else if (timer == PERIOD_LAST) begin
                        step  <= 1'b1;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/vga_box_ctrl.sv
// Overlay-box position controller. Turns four debounced, auto-repeating
// buttons into saturated pending box origins and commits them to the pixel
// datapath only at frame start, so a box never moves mid-frame.
// Ports:
//   clk40m      - pixel clock
//   rst         - asynchronous active-low reset
//   b_left/b_right/g_up/g_down - raw active-low pushbuttons
//   frame_start - one-cycle pulse when vs_count wraps to 0
//   blue_x      - committed blue box horizontal origin
//   green_y     - committed green box vertical origin
//   pos_update  - one-cycle pulse after a commit that changed an origin
module vga_box_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 400000,
    parameter int unsigned REP_DELAY  = 20000000,
    parameter int unsigned REP_PERIOD = 4000000,
    parameter int unsigned STEP       = 10
) (
    input  logic           clk40m,
    input  logic           rst,
    input  logic           b_left,
    input  logic           b_right,
    input  logic           g_up,
    input  logic           g_down,
    input  logic           frame_start,
    output logic [X_W-1:0] blue_x,
    output logic [Y_W-1:0] green_y,
    output logic           pos_update
);

    localparam int unsigned XE_W = X_W + 1;
    localparam int unsigned YE_W = Y_W + 1;

    localparam logic [X_W-1:0]  X_LO      = X_W'(H_MIN);
    localparam logic [X_W-1:0]  X_HI      = X_W'(H_MAX);
    localparam logic [X_W-1:0]  X_STEP    = X_W'(STEP);
    localparam logic [XE_W-1:0] X_LO_STEP = XE_W'(H_MIN + STEP);
    localparam logic [Y_W-1:0]  Y_LO      = Y_W'(V_MIN);
    localparam logic [Y_W-1:0]  Y_HI      = Y_W'(V_MAX);
    localparam logic [Y_W-1:0]  Y_STEP    = Y_W'(STEP);
    localparam logic [YE_W-1:0] Y_LO_STEP = YE_W'(V_MIN + STEP);

    logic step_left;
    logic step_right;
    logic step_up;
    logic step_down;

    logic [X_W-1:0]  nxt_x;
    logic [X_W-1:0]  nxt_x_next;
    logic [Y_W-1:0]  nxt_y;
    logic [Y_W-1:0]  nxt_y_next;
    logic [XE_W-1:0] x_inc;
    logic [YE_W-1:0] y_inc;

    btn_debounce_rep #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_left (
        .clk  (clk40m),
        .rst_n(rst),
        .btn  (b_left),
        .step (step_left)
    );

    btn_debounce_rep #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_right (
        .clk  (clk40m),
        .rst_n(rst),
        .btn  (b_right),
        .step (step_right)
    );

    btn_debounce_rep #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_up (
        .clk  (clk40m),
        .rst_n(rst),
        .btn  (g_up),
        .step (step_up)
    );

    btn_debounce_rep #(
        .DB_CYCLES (DB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_down (
        .clk  (clk40m),
        .rst_n(rst),
        .btn  (g_down),
        .step (step_down)
    );

    // One extra bit on the increment so the clamp sees the true sum.
    // Opposing steps in the same cycle cancel.
    always_comb begin
        x_inc      = {1'b0, nxt_x} + {1'b0, X_STEP};
        nxt_x_next = nxt_x;
        if (step_right && !step_left) begin
            nxt_x_next = (x_inc > {1'b0, X_HI}) ? X_HI : x_inc[X_W-1:0];
        end else if (step_left && !step_right) begin
            nxt_x_next = ({1'b0, nxt_x} < X_LO_STEP) ? X_LO : nxt_x - X_STEP;
        end
    end

    always_comb begin
        y_inc      = {1'b0, nxt_y} + {1'b0, Y_STEP};
        nxt_y_next = nxt_y;
        if (step_down && !step_up) begin
            nxt_y_next = (y_inc > {1'b0, Y_HI}) ? Y_HI : y_inc[Y_W-1:0];
        end else if (step_up && !step_down) begin
            nxt_y_next = ({1'b0, nxt_y} < Y_LO_STEP) ? Y_LO : nxt_y - Y_STEP;
        end
    end

    // The commit reads the pending value from before this cycle's step, so a
    // step coinciding with frame_start shows up one frame later.
    always_ff @(posedge clk40m or negedge rst) begin
        if (!rst) begin
            nxt_x      <= X_LO;
            nxt_y      <= Y_LO;
            blue_x     <= X_LO;
            green_y    <= Y_LO;
            pos_update <= 1'b0;
        end else begin
            nxt_x <= nxt_x_next;
            nxt_y <= nxt_y_next;
            if (frame_start) begin
                blue_x     <= nxt_x;
                green_y    <= nxt_y;
                pos_update <= (nxt_x != blue_x) || (nxt_y != green_y);
            end else begin
                pos_update <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_box_ctrl.sv
// Self-checking bench for vga_box_ctrl with short debounce/repeat timing.
module tb_vga_box_ctrl;

    localparam int DB    = 4;
    localparam int RD    = 20;
    localparam int RP    = 8;
    localparam int STEPV = 10;
    localparam int XMIN  = 216;
    localparam int XMAX  = 816;
    localparam int YMIN  = 27;
    localparam int YMAX  = 427;

    logic        clk40m = 1'b0;
    logic        rst = 1'b0;
    logic        b_left = 1'b1;
    logic        b_right = 1'b1;
    logic        g_up = 1'b1;
    logic        g_down = 1'b1;
    logic        frame_start = 1'b0;
    logic [10:0] blue_x;
    logic [9:0]  green_y;
    logic        pos_update;

    int n_checks = 0;
    int n_fail = 0;

    vga_box_ctrl #(
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP),
        .STEP      (STEPV)
    ) dut (
        .clk40m     (clk40m),
        .rst        (rst),
        .b_left     (b_left),
        .b_right    (b_right),
        .g_up       (g_up),
        .g_down     (g_down),
        .frame_start(frame_start),
        .blue_x     (blue_x),
        .green_y    (green_y),
        .pos_update (pos_update)
    );

    always #5 clk40m = ~clk40m;

    // Reference model. Buttons: 0 left, 1 right, 2 up, 3 down.
    // A button is accepted when its synced samples (raw delayed two clocks)
    // have all disagreed with the accepted level over the last DB clocks.
    // Step pulses fall one clock after acceptance, then REP_DELAY later,
    // then every REP_PERIOD, for as long as the accepted level stays low.
    int hist [4][DB+2];
    int m_db [4];
    int m_press [4];
    int m_step [4];
    int rv [4];
    int m_nx, m_ny, m_bx, m_gy, m_pos, cyc, k, flip;

    always @(posedge clk40m or negedge rst) begin
        if (!rst) begin
            cyc = 0;
            m_nx = XMIN; m_ny = YMIN; m_bx = XMIN; m_gy = YMIN; m_pos = 0;
            for (int b = 0; b < 4; b++) begin
                m_db[b] = 1; m_step[b] = 0; m_press[b] = -1000;
                for (int i = 0; i < DB + 2; i++) hist[b][i] = 1;
            end
        end else begin
            cyc++;
            rv[0] = int'(b_left); rv[1] = int'(b_right);
            rv[2] = int'(g_up);   rv[3] = int'(g_down);
            if (frame_start) begin
                m_pos = ((m_nx != m_bx) || (m_ny != m_gy)) ? 1 : 0;
                m_bx = m_nx;
                m_gy = m_ny;
            end else begin
                m_pos = 0;
            end
            if (m_step[1] == 1 && m_step[0] == 0)
                m_nx = (m_nx + STEPV > XMAX) ? XMAX : m_nx + STEPV;
            else if (m_step[0] == 1 && m_step[1] == 0)
                m_nx = (m_nx < XMIN + STEPV) ? XMIN : m_nx - STEPV;
            if (m_step[3] == 1 && m_step[2] == 0)
                m_ny = (m_ny + STEPV > YMAX) ? YMAX : m_ny + STEPV;
            else if (m_step[2] == 1 && m_step[3] == 0)
                m_ny = (m_ny < YMIN + STEPV) ? YMIN : m_ny - STEPV;
            for (int b = 0; b < 4; b++) begin
                k = cyc - m_press[b] - 1;
                m_step[b] = (m_db[b] == 0 && (k == 0 || (k >= RD && (k - RD) % RP == 0))) ? 1 : 0;
                for (int i = DB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = rv[b];
                flip = 1;
                for (int i = 2; i < DB + 2; i++) if (hist[b][i] == m_db[b]) flip = 0;
                if (flip == 1) begin
                    m_db[b] = hist[b][2];
                    if (m_db[b] == 0) m_press[b] = cyc;
                end
            end
        end
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: b_left = v;
            1: b_right = v;
            2: g_up = v;
            default: g_down = v;
        endcase
    endtask

    task automatic press(input int b, input int n);
        set_btn(b, 1'b0);
        repeat (n) @(negedge clk40m);
        set_btn(b, 1'b1);
        repeat (12) @(negedge clk40m);
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        @(negedge clk40m);
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        b_left = 1'b1; b_right = 1'b1; g_up = 1'b1; g_down = 1'b1;
        frame_start = 1'b0;
        repeat (2) @(negedge clk40m);
        rst = 1'b1;
        @(negedge clk40m);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk40m);
        n_checks++;
        if (blue_x !== 11'd216) begin
            n_fail++; $display("FAIL reset_blue_x: got %0d expected 216", blue_x);
        end
        n_checks++;
        if (green_y !== 10'd27) begin
            n_fail++; $display("FAIL reset_green_y: got %0d expected 27", green_y);
        end
        n_checks++;
        if (pos_update !== 1'b0) begin
            n_fail++; $display("FAIL reset_pos_update: got %b expected 0", pos_update);
        end
        rst = 1'b1;
        repeat (49) @(negedge clk40m);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd216 || green_y !== 10'd27) begin
            n_fail++;
            $display("FAIL reset_commit: got %0d/%0d expected 216/27", blue_x, green_y);
        end
        n_checks++;
        if (pos_update !== 1'b0) begin
            n_fail++; $display("FAIL reset_commit_pos: got %b expected 0", pos_update);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            b_right = 1'b0;
            repeat (3) @(negedge clk40m);
            b_right = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk40m);
        end
        b_right = 1'b0;
        repeat (15) @(negedge clk40m);
        b_right = 1'b1;
        repeat (12) @(negedge clk40m);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd226 || blue_x !== 11'(m_bx)) begin
            n_fail++;
            $display("FAIL bounce_blue_x: got %0d expected 226 (model %0d)", blue_x, m_bx);
        end
        n_checks++;
        if (pos_update !== 1'b1) begin
            n_fail++; $display("FAIL bounce_pos_update: got %b expected 1", pos_update);
        end
        @(negedge clk40m);
        n_checks++;
        if (pos_update !== 1'b0) begin
            n_fail++; $display("FAIL bounce_pos_single: got %b expected 0", pos_update);
        end
    endtask

    task automatic test_hold_repeat();
        do_reset();
        b_right = 1'b0;
        repeat (50) @(negedge clk40m);
        n_checks++;
        if (blue_x !== 11'd216) begin
            n_fail++; $display("FAIL hold_no_commit: got %0d expected 216", blue_x);
        end
        repeat (50) @(negedge clk40m);
        b_right = 1'b1;
        repeat (15) @(negedge clk40m);
        fs_pulse();
        // Steps at debounce+1, +20, then every 8 clocks: 11 steps in 100 clocks.
        n_checks++;
        if (blue_x !== 11'd326 || blue_x !== 11'(m_bx)) begin
            n_fail++;
            $display("FAIL hold_repeat_x: got %0d expected 326 (model %0d)", blue_x, m_bx);
        end
        n_checks++;
        if (pos_update !== 1'b1) begin
            n_fail++; $display("FAIL hold_repeat_pos: got %b expected 1", pos_update);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        press(1, 700);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd816) begin
            n_fail++; $display("FAIL sat_x_max: got %0d expected 816", blue_x);
        end
        press(0, 10);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd806) begin
            n_fail++; $display("FAIL sat_x_back: got %0d expected 806", blue_x);
        end
        press(1, 10);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd816 || pos_update !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_x_reach: got %0d/%b expected 816/1", blue_x, pos_update);
        end
        press(1, 10);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd816 || pos_update !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_x_hold: got %0d/%b expected 816/0", blue_x, pos_update);
        end
        press(0, 700);
        press(0, 10);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd216) begin
            n_fail++; $display("FAIL sat_x_min: got %0d expected 216", blue_x);
        end
        press(3, 700);
        press(3, 10);
        fs_pulse();
        n_checks++;
        if (green_y !== 10'd427) begin
            n_fail++; $display("FAIL sat_y_max: got %0d expected 427", green_y);
        end
        press(2, 700);
        press(2, 10);
        fs_pulse();
        n_checks++;
        if (green_y !== 10'd27 || green_y !== 10'(m_gy)) begin
            n_fail++;
            $display("FAIL sat_y_min: got %0d expected 27 (model %0d)", green_y, m_gy);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(1, 10);
        press(3, 10);
        fs_pulse();
        b_left = 1'b0; b_right = 1'b0;
        repeat (40) @(negedge clk40m);
        b_left = 1'b1; b_right = 1'b1;
        repeat (12) @(negedge clk40m);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd226 || pos_update !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_x: got %0d/%b expected 226/0", blue_x, pos_update);
        end
        g_up = 1'b0; g_down = 1'b0;
        repeat (40) @(negedge clk40m);
        g_up = 1'b1; g_down = 1'b1;
        repeat (12) @(negedge clk40m);
        fs_pulse();
        n_checks++;
        if (green_y !== 10'd37 || pos_update !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_y: got %0d/%b expected 37/0", green_y, pos_update);
        end
    endtask

    task automatic test_coincident_and_reset();
        do_reset();
        g_down = 1'b0;
        repeat (DB + 3) @(negedge clk40m);
        // frame_start lands on the same clock as the first step pulse.
        frame_start = 1'b1;
        @(negedge clk40m);
        frame_start = 1'b0;
        g_down = 1'b1;
        n_checks++;
        if (green_y !== 10'd27 || green_y !== 10'(m_gy)) begin
            n_fail++;
            $display("FAIL coincide_old: got %0d expected 27 (model %0d)", green_y, m_gy);
        end
        repeat (12) @(negedge clk40m);
        fs_pulse();
        n_checks++;
        if (green_y !== 10'd37 || pos_update !== 1'b1) begin
            n_fail++;
            $display("FAIL coincide_next: got %0d/%b expected 37/1", green_y, pos_update);
        end
        b_right = 1'b0;
        repeat (60) @(negedge clk40m);
        fs_pulse();
        repeat (5) @(negedge clk40m);
        n_checks++;
        if (blue_x === 11'd216) begin
            n_fail++; $display("FAIL prereset_moved: got %0d expected above 216", blue_x);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (blue_x !== 11'd216 || green_y !== 10'd27 || pos_update !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %0d/%0d/%b expected 216/27/0",
                     blue_x, green_y, pos_update);
        end
        @(negedge clk40m);
        rst = 1'b1;
        repeat (DB + 2) @(negedge clk40m);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd216 || pos_update !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rearm: got %0d/%b expected 216/0", blue_x, pos_update);
        end
        b_right = 1'b1;
        repeat (12) @(negedge clk40m);
        fs_pulse();
        n_checks++;
        if (blue_x !== 11'd226 || blue_x !== 11'(m_bx)) begin
            n_fail++;
            $display("FAIL reset_fresh_step: got %0d expected 226 (model %0d)", blue_x, m_bx);
        end
    endtask

    task automatic test_random();
        int seg [4];
        do_reset();
        for (int b = 0; b < 4; b++) seg[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk40m);
            n_checks++;
            if (blue_x !== 11'(m_bx) || green_y !== 10'(m_gy) || pos_update !== m_pos[0]) begin
                n_fail++;
                if (n_fail < 30)
                    $display("FAIL random_cycle%0d: got %0d/%0d/%b expected %0d/%0d/%0d",
                             c, blue_x, green_y, pos_update, m_bx, m_gy, m_pos);
            end
            for (int b = 0; b < 4; b++) begin
                if (seg[b] == 0) begin
                    set_btn(b, ($urandom_range(0, 1) == 1));
                    seg[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 60));
                end
                seg[b]--;
            end
            frame_start = (c % 50 == 49);
        end
        frame_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_hold_repeat();
        test_saturate();
        test_simultaneous();
        test_coincident_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
